// File: rtl/tp_adc_pkg.sv
// ---------------------------------------------------------------------------
// tp_adc_pkg
// Shared types and constants for the touch-panel ADC responder model.
//   - tp_state_e : responder state machine encoding
//   - CB_*       : bit positions inside the 8-bit control byte
//   - DATA_LEN_* : conversion result lengths (12-bit and 8-bit mode)
// ---------------------------------------------------------------------------
package tp_adc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HUNT      = 3'd1,
        CMD       = 3'd2,
        BUSY_WAIT = 3'd3,
        CONV      = 3'd4,
        DATA      = 3'd5
    } tp_state_e;

    // Control byte layout: S A2 A1 A0 MODE SER/DFR PD1 PD0
    localparam int CB_START = 7;
    localparam int CB_A_HI  = 6;
    localparam int CB_A_LO  = 4;
    localparam int CB_MODE  = 3;
    localparam int CB_SER   = 2;
    localparam int CB_PD_HI = 1;
    localparam int CB_PD_LO = 0;

    localparam logic [3:0] DATA_LEN_12 = 4'd12;
    localparam logic [3:0] DATA_LEN_8  = 4'd8;

    // MODE=1 selects the short 8-bit conversion.
    function automatic logic [3:0] data_len(input logic mode8);
        return mode8 ? DATA_LEN_8 : DATA_LEN_12;
    endfunction

endpackage

// File: rtl/tp_adc_responder_if.sv
// ---------------------------------------------------------------------------
// tp_adc_responder_if
// The four-wire SPI link plus BUSY and PENIRQ_N between the touch panel
// controller (master) and the ADC (slave).
//   TP_SCLK_I, TP_SS_N_I, TP_MOSI_I : driven by the master
//   TP_MISO_O, TP_BUSY_O, TP_PENIRQ_N_O : driven by the ADC
// Signal names keep the ADC-side pin names used across the LTM codebase.
// ---------------------------------------------------------------------------
interface tp_adc_responder_if;

    logic TP_SCLK_I;
    logic TP_SS_N_I;
    logic TP_MOSI_I;
    logic TP_MISO_O;
    logic TP_BUSY_O;
    logic TP_PENIRQ_N_O;

    modport master (
        output TP_SCLK_I, TP_SS_N_I, TP_MOSI_I,
        input  TP_MISO_O, TP_BUSY_O, TP_PENIRQ_N_O
    );

    modport slave (
        input  TP_SCLK_I, TP_SS_N_I, TP_MOSI_I,
        output TP_MISO_O, TP_BUSY_O, TP_PENIRQ_N_O
    );

endinterface

// File: rtl/tp_sync_edge.sv
// ---------------------------------------------------------------------------
// tp_sync_edge
// Synchronizes one asynchronous input into the Clock domain and derives
// single-cycle rise/fall strobes from the synchronized level.
//   Clock, Resetn : system clock, synchronous active-low reset
//   async_in      : asynchronous input
//   level         : synchronized level (SYNC_STAGES flops of latency)
//   rise / fall   : one-Clock pulses on synchronized transitions
// RESET_LEVEL sets the reset value of the chain; an idle-high input such as
// a chip select resets high so no phantom edge appears after reset.
// ---------------------------------------------------------------------------
module tp_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            prev_q <= RESET_LEVEL;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(async_in);
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tp_adc_responder.sv
// ---------------------------------------------------------------------------
// tp_adc_responder
// Behavioural ADS7843-style touch ADC that answers the LTM touch panel
// controller's SPI transactions, so the LTM top can be simulated without
// the physical panel.
//   Clock, Resetn  : system clock, synchronous active-low reset
//   Touch_I        : 1 = panel pressed
//   X_Value_I      : X coordinate reported for the X channel
//   Y_Value_I      : Y coordinate reported for the Y channel
//   tp (slave)     : SCLK/SS_N/MOSI in, MISO/BUSY/PENIRQ_N out
//   Cmd_Valid_O    : one-cycle pulse when a control byte is decoded
//   Cmd_O          : last decoded control byte
// All outputs are registered and react one Clock after an input strobe.
// ---------------------------------------------------------------------------
module tp_adc_responder
    import tp_adc_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] X_CHANNEL   = 3'b101,
    parameter logic [2:0] Y_CHANNEL   = 3'b001
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Touch_I,
    input  logic [11:0]         X_Value_I,
    input  logic [11:0]         Y_Value_I,
    tp_adc_responder_if.slave   tp,
    output logic                Cmd_Valid_O,
    output logic [7:0]          Cmd_O
);

    // ----------------------------------------------------------------- input conditioning
    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise_unused, ss_fall_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    tp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
        .Clock(Clock), .Resetn(Resetn), .async_in(tp.TP_SCLK_I),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Chip select idles high; resetting the chain high keeps the responder
    // in IDLE while the real level propagates after reset.
    tp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_ss_sync (
        .Clock(Clock), .Resetn(Resetn), .async_in(tp.TP_SS_N_I),
        .level(ss_level), .rise(ss_rise_unused), .fall(ss_fall_unused)
    );

    tp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi_sync (
        .Clock(Clock), .Resetn(Resetn), .async_in(tp.TP_MOSI_I),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // ----------------------------------------------------------------- state
    tp_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  data_cnt_q, data_cnt_d;
    logic [11:0] snap_q, snap_d;
    logic        mode8_q, mode8_d;
    logic        miso_q, miso_d;
    logic        busy_q, busy_d;
    logic        penirq_n_q, penirq_n_d;
    logic        pen_en_q, pen_en_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  byte_v;
    logic        pen_active;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_cnt_q  <= '0;
            snap_q      <= '0;
            mode8_q     <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            penirq_n_q  <= 1'b1;
            pen_en_q    <= 1'b1;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_cnt_q  <= data_cnt_d;
            snap_q      <= snap_d;
            mode8_q     <= mode8_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            penirq_n_q  <= penirq_n_d;
            pen_en_q    <= pen_en_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    // The pen interrupt is masked for the whole conversion, as on the real part.
    assign pen_active = pen_en_q && !(state_q inside {BUSY_WAIT, CONV, DATA});

    always_comb begin
        // NOTE: every variable gets its default first, so no branch can leave
        // one unassigned and infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_cnt_d  = data_cnt_q;
        snap_d      = snap_q;
        mode8_d     = mode8_q;
        miso_d      = miso_q;
        busy_d      = busy_q;
        pen_en_d    = pen_en_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        penirq_n_d  = ~(Touch_I & pen_active);

        // Partial byte with the current MOSI bit placed at its MSB-first slot.
        byte_v = shift_q;
        byte_v[3'(4'd7 - bit_cnt_q)] = mosi_level;

        if (ss_level) begin
            // Deselect aborts from any state and beats a coincident SCLK edge.
            state_d    = IDLE;
            miso_d     = 1'b0;
            busy_d     = 1'b0;
            shift_d    = '0;
            bit_cnt_d  = '0;
            data_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    miso_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = HUNT;
                end
                HUNT: begin
                    // Leading zeros before the start bit are ignored.
                    if (sclk_rise && mosi_level) begin
                        shift_d           = '0;
                        shift_d[CB_START] = 1'b1;
                        bit_cnt_d         = 4'd1;
                        state_d           = CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == 4'd7) begin
                            cmd_d       = byte_v;
                            cmd_valid_d = 1'b1;
                            mode8_d     = byte_v[CB_MODE];
                            pen_en_d    = (byte_v[CB_PD_HI:CB_PD_LO] == 2'b00);
                            if (byte_v[CB_A_HI:CB_A_LO] == X_CHANNEL)
                                snap_d = X_Value_I;
                            else if (byte_v[CB_A_HI:CB_A_LO] == Y_CHANNEL)
                                snap_d = Y_Value_I;
                            else
                                snap_d = 12'h000;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            state_d   = BUSY_WAIT;
                        end else begin
                            shift_d   = byte_v;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                BUSY_WAIT: begin
                    if (sclk_fall) begin
                        busy_d  = 1'b1;
                        state_d = CONV;
                    end
                end
                CONV: begin
                    if (sclk_fall) begin
                        busy_d     = 1'b0;
                        miso_d     = snap_q[11];
                        data_cnt_d = 4'd1;
                        state_d    = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        if (data_cnt_q == data_len(mode8_q)) begin
                            miso_d     = 1'b0;
                            data_cnt_d = '0;
                            state_d    = HUNT;
                        end else begin
                            // 8-bit mode stops early, so it sends snap[11:4].
                            miso_d     = snap_q[4'd11 - data_cnt_q];
                            data_cnt_d = data_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign tp.TP_MISO_O     = miso_q;
    assign tp.TP_BUSY_O     = busy_q;
    assign tp.TP_PENIRQ_N_O = penirq_n_q;
    assign Cmd_Valid_O      = cmd_valid_q;
    assign Cmd_O            = cmd_q;

endmodule

// File: tb/tb_tp_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_tp_adc_responder
// Self-checking bench: acts as the touch panel controller (SPI master),
// runs a table of full transactions and a few hand-written corner cases.
// ---------------------------------------------------------------------------
module tb_tp_adc_responder;
    import tp_adc_pkg::*;

    logic        Clock;
    logic        Resetn;
    logic        Touch_I;
    logic [11:0] X_Value_I;
    logic [11:0] Y_Value_I;
    logic        Cmd_Valid_O;
    logic [7:0]  Cmd_O;

    tp_adc_responder_if tp ();

    tp_adc_responder dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Touch_I     (Touch_I),
        .X_Value_I   (X_Value_I),
        .Y_Value_I   (Y_Value_I),
        .tp          (tp.slave),
        .Cmd_Valid_O (Cmd_Valid_O),
        .Cmd_O       (Cmd_O)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;

    logic [11:0] sb[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [11:0] x;
        logic [11:0] y;
        int          nbits;
        int          change_at;
        logic [11:0] new_x;
        logic [11:0] exp_word;
        logic        exp_penirq_n;
    } vec_t;

    vec_t vecs[4];

    // Cumulative monitors; transactions look at the deltas.
    always @(negedge Clock) begin
        if (Cmd_Valid_O) valid_cnt++;
        if (tp.TP_BUSY_O) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SCLK period: MOSI set while low, MISO sampled at the rising edge.
    task automatic sclk_cycle(input logic mosi, output logic miso);
        tp.TP_MOSI_I = mosi;
        repeat (8) @(negedge Clock);
        miso = tp.TP_MISO_O;
        tp.TP_SCLK_I = 1'b1;
        repeat (8) @(negedge Clock);
        tp.TP_SCLK_I = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        logic        m;
        logic [11:0] word;
        logic [11:0] exp_w;
        int          v0, b0;
        X_Value_I = v.x;
        Y_Value_I = v.y;
        Touch_I   = 1'b1;
        v0 = valid_cnt;
        b0 = busy_cnt;
        sb.push_back(v.exp_word);
        tp.TP_SS_N_I = 1'b0;
        repeat (8) @(negedge Clock);
        for (int i = 0; i < 2; i++) sclk_cycle(1'b0, m);
        for (int i = 0; i < 8; i++) sclk_cycle(v.cmd[7-i], m);
        sclk_cycle(1'b0, m);
        check("penirq_masked_conv", 32'(tp.TP_PENIRQ_N_O), 32'd1);
        word = '0;
        for (int i = 0; i < v.nbits; i++) begin
            if (i == v.change_at) X_Value_I = v.new_x;
            sclk_cycle(1'b0, m);
            word = {word[10:0], m};
        end
        repeat (8) @(negedge Clock);
        check("miso_after_data", 32'(tp.TP_MISO_O), 32'd0);
        check("busy_one_sclk", 32'(busy_cnt - b0), 32'd16);
        check("cmd_valid_once", 32'(valid_cnt - v0), 32'd1);
        check("cmd_o", 32'(Cmd_O), 32'(v.cmd));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp_w = sb.pop_front();
            check("data_word", 32'(word), 32'(exp_w));
        end
        tp.TP_SS_N_I = 1'b1;
        repeat (8) @(negedge Clock);
        check("penirq_after", 32'(tp.TP_PENIRQ_N_O), 32'(v.exp_penirq_n));
        check("busy_idle", 32'(tp.TP_BUSY_O), 32'd0);
    endtask

    initial begin
        logic m;
        int   v0;
        vec_t hv;

        vecs[0] = '{cmd: 8'hD0, x: 12'hA5C, y: 12'h111, nbits: 12, change_at: -1, new_x: 12'h000, exp_word: 12'hA5C, exp_penirq_n: 1'b0};
        vecs[1] = '{cmd: 8'h98, x: 12'h222, y: 12'h3F7, nbits: 8,  change_at: -1, new_x: 12'h000, exp_word: 12'h03F, exp_penirq_n: 1'b0};
        vecs[2] = '{cmd: 8'hA0, x: 12'hFFF, y: 12'hFFF, nbits: 12, change_at: -1, new_x: 12'h000, exp_word: 12'h000, exp_penirq_n: 1'b0};
        vecs[3] = '{cmd: 8'hD3, x: 12'h5A3, y: 12'h000, nbits: 12, change_at: -1, new_x: 12'h000, exp_word: 12'h5A3, exp_penirq_n: 1'b1};

        tp.TP_SCLK_I = 1'b0;
        tp.TP_SS_N_I = 1'b1;
        tp.TP_MOSI_I = 1'b0;
        Touch_I   = 1'b1;
        X_Value_I = '0;
        Y_Value_I = '0;
        Resetn    = 1'b0;
        repeat (4) @(negedge Clock);
        check("rst_penirq", 32'(tp.TP_PENIRQ_N_O), 32'd1);
        check("rst_miso", 32'(tp.TP_MISO_O), 32'd0);
        check("rst_busy", 32'(tp.TP_BUSY_O), 32'd0);
        check("rst_cmd_valid", 32'(Cmd_Valid_O), 32'd0);
        check("rst_cmd", 32'(Cmd_O), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);
        check("penirq_after_rst", 32'(tp.TP_PENIRQ_N_O), 32'd0);
        repeat (4) @(negedge Clock);

        for (int i = 0; i < 4; i++) do_txn(vecs[i]);

        // Abort after the 5th command bit of 8'hD0 (start + 4 bits).
        v0 = valid_cnt;
        tp.TP_SS_N_I = 1'b0;
        repeat (8) @(negedge Clock);
        sclk_cycle(1'b0, m);
        sclk_cycle(1'b1, m);
        sclk_cycle(1'b1, m);
        sclk_cycle(1'b0, m);
        sclk_cycle(1'b1, m);
        sclk_cycle(1'b0, m);
        tp.TP_SS_N_I = 1'b1;
        repeat (8) @(negedge Clock);
        check("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_cmd_kept", 32'(Cmd_O), 32'hD3);
        check("abort_miso", 32'(tp.TP_MISO_O), 32'd0);

        // Full Y transaction after the abort; PD=00 re-enables the pen IRQ.
        hv = '{cmd: 8'h90, x: 12'h777, y: 12'hB6D, nbits: 12, change_at: -1, new_x: 12'h000, exp_word: 12'hB6D, exp_penirq_n: 1'b0};
        do_txn(hv);

        // X changes mid-DATA; the word sent is the one captured at decode.
        hv = '{cmd: 8'hD0, x: 12'h123, y: 12'h000, nbits: 12, change_at: 4, new_x: 12'hFFF, exp_word: 12'h123, exp_penirq_n: 1'b0};
        do_txn(hv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tp_adc_responder.md
Name: tp_adc_responder

Overview:
- Behavioural-RTL model of the touch-panel ADC (ADS7843-style serial ADC) at the far end of the LTM touch interface.
- Answers the existing touch panel controller's SPI transactions so that the LTM top level can be simulated, and HW-in-loop tested, without the physical panel.
- Samples the master's SCLK, SS_N and MOSI on the system clock and decodes the 8-bit control byte.
- Drives BUSY, shifts out a 12-bit or 8-bit coordinate on MISO, and drives PENIRQ_N from a touch input.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input.
- X_CHANNEL, 3'b101, A2:A0 code that returns X_Value_I.
- Y_CHANNEL, 3'b001, A2:A0 code that returns Y_Value_I.

Ports:
- Clock  in  1  system clock (50 MHz).
- Resetn  in  1  synchronous active-low reset.
- Touch_I  in  1  1 = panel pressed.
- X_Value_I  in  12  X coordinate to report.
- Y_Value_I  in  12  Y coordinate to report.
- TP_SCLK_I  in  1  SPI clock from master (DCLK).
- TP_SS_N_I  in  1  chip select, active low.
- TP_MOSI_I  in  1  master data (DIN).
- TP_MISO_O  out  1  responder data (DOUT).
- TP_BUSY_O  out  1  conversion busy.
- TP_PENIRQ_N_O  out  1  pen interrupt, active low.
- Cmd_Valid_O  out  1  one-cycle pulse when a control byte is decoded.
- Cmd_O  out  8  last decoded control byte.

Behaviour:
- One clock domain, Clock. Reset is synchronous and active-low, port Resetn. All outputs are registered.
- Reset values:
  - TP_MISO_O=0, TP_BUSY_O=0, TP_PENIRQ_N_O=1, Cmd_Valid_O=0, Cmd_O=8'h00.
  - state=IDLE, all counters and shift registers 0.
- Input conditioning:
  - SCLK, SS_N and MOSI each pass through SYNC_STAGES flops.
  - SCLK and SS_N are then edge-detected; rise/fall strobes are 1-cycle pulses.
  - Outputs react exactly 1 Clock after the strobe.
  - Requirement on the master: SCLK high and low times are each >= SYNC_STAGES+3 Clock periods. The existing controller meets this.
- State machine:
  - IDLE: MISO=0, BUSY=0. SS_N synchronized low -> HUNT.
  - HUNT: on each SCLK rise, if MOSI=1 then it is the start bit: load it into shift bit 7, bit count=1 -> CMD. MOSI=0 bits are ignored.
  - CMD: on each SCLK rise, shift MOSI in MSB-first. When the count reaches 8:
    - Cmd_O <= byte; Cmd_Valid_O pulses 1 cycle.
    - Snapshot data: X_Value_I if A2:A0 (bits 6:4)=X_CHANNEL; Y_Value_I if =Y_CHANNEL; 12'h000 otherwise.
    - Go to BUSY_WAIT.
  - BUSY_WAIT: next SCLK fall -> BUSY=1 -> CONV.
  - CONV: next SCLK fall -> BUSY=0; MISO <= snapshot MSB; data count=1 -> DATA.
  - DATA:
    - Length is 12 bits, or 8 bits if MODE (bit 3)=1. In 8-bit mode the snapshot's upper 8 bits are sent.
    - On each SCLK fall, MISO <= next bit, MSB-first.
    - On the fall after the last bit, MISO <= 0 -> HUNT. This allows back-to-back commands within one SS_N low period.
- Abort: SS_N synchronized high in any state -> IDLE next cycle.
  - MISO=0, BUSY=0; no Cmd_Valid_O pulse.
  - A partial byte is discarded.
- Simultaneous SS_N rise and SCLK edge: the abort wins.
- PENIRQ_N:
  - TP_PENIRQ_N_O <= ~(Touch_I & pen_en).
  - pen_en = 1 at reset. On each decoded command, pen_en = (PD1:PD0, bits 1:0 == 2'b00).
  - pen_en is forced 0 while state is BUSY_WAIT, CONV or DATA.
  - Latency 1 Clock from Touch_I.
- Snapshot width: 12 bits, no arithmetic. The count registers are 4 bits and never wrap, because the state exits at the terminal count.

Decomposition:
- Package tp_adc_pkg:
  - state enum (IDLE, HUNT, CMD, BUSY_WAIT, CONV, DATA);
  - control-byte field positions (START=7, A=6:4, MODE=3, SER=2, PD=1:0);
  - data lengths 12 and 8.
- Sub-module tp_sync_edge (params SYNC_STAGES; outputs level, rise, fall). Instantiated for SCLK and SS_N; MOSI uses its level output only.

Test Plan:
- Reset with Touch_I=1 -> TP_PENIRQ_N_O=1 during reset; TP_PENIRQ_N_O=0 one cycle after reset release; MISO=0, BUSY=0.
- SS_N low, 2 zero bits then byte 8'hD0 (X, 12-bit, PD=00), X_Value_I=12'hA5C:
  - Cmd_Valid_O pulses once with Cmd_O=8'hD0;
  - BUSY is high for exactly one SCLK period;
  - MISO bits read on the master's rising edges = 1010_0101_1100.
- Byte 8'h98 (Y, 8-bit mode), Y_Value_I=12'h3F7 -> 8 data bits = 0011_1111, then MISO=0.
- Byte 8'hA0 (A2:A0=010) -> 12 zero data bits; Cmd_O=8'hA0.
- Byte 8'hD3 (PD=11) with Touch_I=1 -> TP_PENIRQ_N_O stays 1 after the transaction.
- Abort: SS_N raised after the 5th command bit -> state IDLE, no Cmd_Valid_O. A following full 8'h90 transaction returns Y_Value_I correctly.
- Change X_Value_I mid-DATA from 12'h123 to 12'hFFF -> transmitted word is still 12'h123.
